// File: rtl/rv_core_sequencer.sv
// rv_core_sequencer: multi-cycle control FSM around the single-cycle datapath.
// Owns the PC, fetches over imem_*, holds core_instr/core_pc stable, forwards
// loads/stores over dmem_*, strobes core_commit and updates the PC.
// Ports: clk, rst (async high), run; imem_req/addr/ready/rdata;
// core_instr/pc/next_pc/pc_j_valid/read/write/addr/wdata/commit;
// dmem_req/we/addr/wdata/ready; halted, bus_err (sticky).
// Optional macro RV_SEQ_RETIRE_CNT_EN adds output retire_count[31:0].
module rv_core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] core_instr,
    output logic [31:0] core_pc,
    input  logic [31:0] core_next_pc,
    input  logic        core_pc_j_valid,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_commit,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    output logic        halted,
    output logic        bus_err
`ifdef RV_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_COMMIT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] daddr_q;
    logic [31:0] dwdata_q;
    logic        dwe_q;
    logic [7:0]  wait_q;
    logic        entering_wait;
    logic        waiting;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // A ready on the timeout cycle still wins.
                if (imem_ready)             state_d = S_EXEC;
                else if (wait_q == TIMEOUT) state_d = S_ERROR;
            end
            S_EXEC: begin
                if (ir_q == EBREAK)               state_d = S_HALT;
                else if (core_read && core_write) state_d = S_ERROR;
                else if (core_read || core_write) state_d = S_MEM;
                else                              state_d = S_COMMIT;
            end
            S_MEM: begin
                if (dmem_ready)             state_d = S_COMMIT;
                else if (wait_q == TIMEOUT) state_d = S_ERROR;
            end
            S_COMMIT: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: state_d = state_q;
        endcase
    end

    assign entering_wait = (state_d != state_q) &&
                           (state_d == S_FETCH || state_d == S_MEM);
    assign waiting = (state_q == S_FETCH && !imem_ready) ||
                     (state_q == S_MEM && !dmem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= NOP;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dwe_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q <= state_d;
            if (entering_wait) wait_q <= '0;
            else if (waiting)  wait_q <= wait_q + 8'd1;
            if (state_q == S_FETCH && imem_ready) ir_q <= imem_rdata;
            if (state_q == S_EXEC && state_d == S_MEM) begin
                daddr_q  <= core_addr;
                dwdata_q <= core_wdata;
                dwe_q    <= core_write;
            end
            if (state_q == S_COMMIT)
                pc_q <= core_pc_j_valid ? core_next_pc : pc_q + 32'd4;
        end
    end

`ifdef RV_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    retire_count <= '0;
        else if (state_q == S_COMMIT) retire_count <= retire_count + 32'd1;
    end
`endif

    // Requests decode straight from state so reset drops them at once.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign core_instr  = ir_q;
    assign core_pc     = pc_q;
    assign core_commit = (state_q == S_COMMIT);
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = (state_q == S_MEM) && dwe_q;
    assign dmem_addr   = daddr_q;
    assign dmem_wdata  = dwdata_q;
    assign halted      = (state_q == S_HALT);
    assign bus_err     = (state_q == S_ERROR);

endmodule

// File: tb/tb_rv_core_sequencer.sv
// tb_rv_core_sequencer: table vectors, randomized instructions against a
// latency/PC model, and hand sequences for timeout, halt, error and reset.
module tb_rv_core_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int TMO = 4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] core_instr;
    logic [31:0] core_pc;
    logic [31:0] core_next_pc = '0;
    logic        core_pc_j_valid = 1'b0;
    logic        core_read = 1'b0;
    logic        core_write = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_commit;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic        halted;
    logic        bus_err;
`ifdef RV_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    rv_core_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .core_instr(core_instr), .core_pc(core_pc),
        .core_next_pc(core_next_pc), .core_pc_j_valid(core_pc_j_valid),
        .core_read(core_read), .core_write(core_write),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_commit(core_commit),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready),
        .halted(halted), .bus_err(bus_err)
`ifdef RV_SEQ_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        jv;
        logic [31:0] tgt;
        int          iw;
        int          dw;
        int          lat;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_pc;
    int n_commit;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs;
        imem_ready = 0; imem_rdata = '0; dmem_ready = 0;
        core_read = 0; core_write = 0; core_pc_j_valid = 0;
        core_addr = '0; core_wdata = '0; core_next_pc = '0;
    endtask

    // Leaves the bench at a falling edge with the DUT in its first FETCH cycle.
    task automatic do_reset;
        @(negedge clk);
        rst = 1; run = 0;
        clear_inputs();
        @(negedge clk);
        rst = 0; run = 1;
        exp_pc = RST_PC;
        n_commit = 0;
        @(negedge clk);
    endtask

    // Reactive memory and datapath for one instruction; measures latency.
    task automatic do_instr(input vec_t v, input string tag);
        int iwc = 0, dwc = 0, cyc = 0;
        bit done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            cyc++;
            imem_ready = 0; dmem_ready = 0;
            if (core_commit) begin
                chk({tag, " commit instr"}, core_instr, v.instr);
                chk({tag, " commit pc"}, core_pc, exp_pc);
                core_pc_j_valid = v.jv; core_next_pc = v.tgt;
                core_read = 0; core_write = 0;
                done = 1;
            end else if (imem_req) begin
                chk({tag, " imem_addr"}, imem_addr, exp_pc);
                imem_rdata = v.instr;
                if (iwc == v.iw) begin
                    imem_ready = 1;
                    core_read = v.rd; core_write = v.wr;
                    core_addr = v.addr; core_wdata = v.wdata;
                end
                iwc++;
            end else if (dmem_req) begin
                chk({tag, " dmem_we"}, 32'(dmem_we), 32'(v.wr));
                chk({tag, " dmem_addr"}, dmem_addr, v.addr);
                chk({tag, " dmem_wdata"}, dmem_wdata, v.wdata);
                chk({tag, " mem instr"}, core_instr, v.instr);
                if (dwc == v.dw) dmem_ready = 1;
                dwc++;
                core_addr = ~v.addr; core_wdata = ~v.wdata;
            end else if (bus_err || halted) begin
                c = 40;
            end
            @(negedge clk);
        end
        imem_ready = 0; dmem_ready = 0;
        core_pc_j_valid = 0;
        chk({tag, " commit seen"}, 32'(done), 32'd1);
        chk({tag, " latency"}, cyc, v.lat);
        chk({tag, " commit one cycle"}, 32'(core_commit), 32'd0);
        exp_pc = v.jv ? v.tgt : exp_pc + 32'd4;
        n_commit++;
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = '{32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 3};
        tbl[1] = '{32'h0021_0623, 0, 1, 32'h10, 32'hAB, 0, 0, 0, 2, 6};
        tbl[2] = '{32'h0001_2083, 1, 0, 32'h20, 32'h55, 0, 0, 1, 0, 5};
        tbl[3] = '{32'h0000_006F, 0, 0, 0, 0, 1, 32'h100, 0, 0, 3};
        tbl[4] = '{32'h0000_0013, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 3};
        tbl[5] = '{32'h0000_0013, 0, 0, 0, 0, 0, 0, 4, 0, 7};
        tbl[6] = '{32'h00A1_2023, 0, 1, 32'hFFFF_FFF0, 32'hDEAD_BEEF,
                   0, 0, 0, 4, 8};
        tbl[7] = '{32'h0000_0013, 0, 0, 0, 0, 1, 32'h0000_0203, 0, 0, 3};

        @(negedge clk);
        chk("reset imem_req", 32'(imem_req), 0);
        chk("reset dmem_req", 32'(dmem_req), 0);
        chk("reset core_pc", core_pc, RST_PC);
        chk("reset core_instr", core_instr, 32'h0000_0013);
        chk("reset commit", 32'(core_commit), 0);
        chk("reset dmem_addr", dmem_addr, 0);
        chk("reset dmem_wdata", dmem_wdata, 0);
        chk("reset halted", 32'(halted), 0);
        chk("reset bus_err", 32'(bus_err), 0);
`ifdef RV_SEQ_RETIRE_CNT_EN
        chk("reset retire_count", retire_count, 0);
`endif
        rst = 0;
        @(negedge clk);
        chk("idle imem_req", 32'(imem_req), 0);
        run = 1;
        exp_pc = RST_PC;
        n_commit = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_instr(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            rv.instr = $urandom;
            if (rv.instr == EBREAK) rv.instr = 32'h0000_0013;
            rv.rd = (kind == 1);
            rv.wr = (kind == 2);
            rv.addr = $urandom;
            rv.wdata = $urandom;
            rv.jv = $urandom_range(0, 1) == 1;
            rv.tgt = $urandom;
            rv.iw = int'($urandom_range(0, TMO));
            rv.dw = int'($urandom_range(0, TMO));
            rv.lat = 3 + rv.iw + ((kind != 0) ? 1 + rv.dw : 0);
            do_instr(rv, $sformatf("rnd%0d", i));
        end
`ifdef RV_SEQ_RETIRE_CNT_EN
        chk("retire_count", retire_count, 32'(n_commit));
`endif

        // run dropped mid-instruction: the instruction still retires
        do_reset();
        run = 0;
        do_instr(tbl[0], "rundrop");
        chk("rundrop idle", 32'(imem_req), 0);
        @(negedge clk);
        chk("rundrop idle2", 32'(imem_req), 0);
        run = 1;
        @(negedge clk);
        do_instr(tbl[0], "resume");
        chk("resume pc", core_pc, 32'h8);

        // fetch timeout: no ready ever
        begin
            int reqs = 0;
            do_reset();
            for (int c = 0; c < 20 && !bus_err; c++) begin
                if (imem_req) reqs++;
                @(negedge clk);
            end
            chk("itmo bus_err", 32'(bus_err), 1);
            chk("itmo req cycles", reqs, TMO + 1);
            for (int c = 0; c < 3; c++) begin
                chk("itmo imem_req low", 32'(imem_req), 0);
                @(negedge clk);
            end
            chk("itmo sticky", 32'(bus_err), 1);
        end

        // data timeout on a store
        begin
            int reqs = 0;
            do_reset();
            imem_ready = 1; imem_rdata = 32'h0021_0623;
            @(negedge clk);
            imem_ready = 0; core_write = 1;
            @(negedge clk);
            core_write = 0;
            for (int c = 0; c < 20 && !bus_err; c++) begin
                if (dmem_req) reqs++;
                @(negedge clk);
            end
            chk("dtmo bus_err", 32'(bus_err), 1);
            chk("dtmo req cycles", reqs, TMO + 1);
            chk("dtmo dmem_req low", 32'(dmem_req), 0);
        end

        // EBREAK halts without retiring
        do_reset();
        imem_ready = 1; imem_rdata = EBREAK;
        @(negedge clk);
        imem_ready = 0;
        chk("ebreak exec halted", 32'(halted), 0);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            chk("halt halted", 32'(halted), 1);
            chk("halt commit", 32'(core_commit), 0);
            chk("halt imem_req", 32'(imem_req), 0);
            @(negedge clk);
        end

        // simultaneous read and write is illegal
        do_reset();
        imem_ready = 1; imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_ready = 0; core_read = 1; core_write = 1;
        @(negedge clk);
        core_read = 0; core_write = 0;
        chk("rdwr bus_err", 32'(bus_err), 1);
        chk("rdwr dmem_req", 32'(dmem_req), 0);
        chk("rdwr commit", 32'(core_commit), 0);

        // asynchronous reset in the middle of a store
        do_reset();
        do_instr(tbl[0], "prestore");
        imem_ready = 1; imem_rdata = 32'h0021_0623;
        @(negedge clk);
        imem_ready = 0; core_write = 1;
        core_addr = 32'h10; core_wdata = 32'hAB;
        @(negedge clk);
        chk("midmem dmem_req", 32'(dmem_req), 1);
        chk("midmem pc", core_pc, 32'h4);
        #2 rst = 1;
        #1;
        chk("rst dmem_req", 32'(dmem_req), 0);
        chk("rst pc", imem_addr, RST_PC);
        chk("rst dmem_addr", dmem_addr, 0);
`ifdef RV_SEQ_RETIRE_CNT_EN
        chk("rst retire_count", retire_count, 0);
`endif
        clear_inputs();
        @(negedge clk);
        rst = 0;
        exp_pc = RST_PC;
        @(negedge clk);
        do_instr(tbl[0], "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
